// File: rtl/lc_3_mmio_if.sv
// CPU memory-port bus between the lc_3 core (master) and the MMIO responder (slave).
interface lc_3_mmio_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  io_hit;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  io_hit, mem_rdata, mem_ready
  );

  modport slave (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output io_hit, mem_rdata, mem_ready
  );
endinterface

// File: rtl/lc_3_mmio.sv
// LC-3 device-register responder: KBSR/KBDR/DSR/DDR/MCR decode, keyboard FIFO,
// valid/ready display port and interrupt request.
module lc_3_mmio #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  lc_3_mmio_if.slave bus,
  input  logic       kb_valid,
  input  logic [7:0] kb_data,
  output logic       kb_ready,
  output logic       disp_valid,
  output logic [7:0] disp_data,
  input  logic       disp_ready,
  output logic       irq,
  output logic       run
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] KBSR_ADDR = ADDR_WIDTH'(16'hFE00);
  localparam logic [ADDR_WIDTH-1:0] KBDR_ADDR = ADDR_WIDTH'(16'hFE02);
  localparam logic [ADDR_WIDTH-1:0] DSR_ADDR  = ADDR_WIDTH'(16'hFE04);
  localparam logic [ADDR_WIDTH-1:0] DDR_ADDR  = ADDR_WIDTH'(16'hFE06);
  localparam logic [ADDR_WIDTH-1:0] MCR_ADDR  = ADDR_WIDTH'(16'hFFFE);

  localparam int unsigned STAT_BIT = DATA_WIDTH - 1;
  localparam int unsigned IE_BIT   = DATA_WIDTH - 2;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_KBSR,
    SEL_KBDR,
    SEL_DSR,
    SEL_DDR,
    SEL_MCR
  } sel_e;

  sel_e                  sel;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic                  irq_next;

  logic [7:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  logic                  kb_ie;
  logic                  dsp_ie;
  logic [DATA_WIDTH-1:0] mcr;
  logic                  disp_hs;
  logic                  ddr_load;

  always_comb begin
    sel = SEL_NONE;
    case (bus.mem_addr)
      KBSR_ADDR: sel = SEL_KBSR;
      KBDR_ADDR: sel = SEL_KBDR;
      DSR_ADDR:  sel = SEL_DSR;
      DDR_ADDR:  sel = SEL_DDR;
      MCR_ADDR:  sel = SEL_MCR;
      default:   sel = SEL_NONE;
    endcase
  end

  assign bus.io_hit = bus.mem_en && (sel != SEL_NONE);
  assign rd_acc     = bus.io_hit && !bus.mem_we;
  assign wr_acc     = bus.io_hit && bus.mem_we;

  assign fifo_empty = (count == '0);
  assign kb_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign push       = kb_valid && kb_ready;
  assign pop        = rd_acc && (sel == SEL_KBDR) && !fifo_empty;

  // Both terms look at the pre-edge disp_valid, so they can never fire together;
  // a DDR write that coincides with a handshake is dropped.
  assign disp_hs    = disp_valid && disp_ready;
  assign ddr_load   = wr_acc && (sel == SEL_DDR) && !disp_valid;

  assign run        = mcr[STAT_BIT];

  always_comb begin
    rdata_next = '0;
    if (rd_acc) begin
      case (sel)
        SEL_KBSR: begin
          rdata_next[STAT_BIT] = !fifo_empty;
          rdata_next[IE_BIT]   = kb_ie;
        end
        SEL_KBDR: begin
          if (!fifo_empty) rdata_next[7:0] = fifo_mem[rd_ptr];
        end
        SEL_DSR: begin
          rdata_next[STAT_BIT] = !disp_valid;
          rdata_next[IE_BIT]   = dsp_ie;
        end
        SEL_DDR:  rdata_next[7:0] = disp_data;
        SEL_MCR:  rdata_next = mcr;
        default:  rdata_next = '0;
      endcase
    end
  end

  assign irq_next = (!fifo_empty && kb_ie) || (!disp_valid && dsp_ie);

  // Storage is not reset; pointer/count reset is what discards the contents.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= kb_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      kb_ie         <= 1'b0;
      dsp_ie        <= 1'b0;
      mcr           <= '0;
      mcr[STAT_BIT] <= 1'b1;
    end else if (wr_acc) begin
      case (sel)
        SEL_KBSR: kb_ie  <= bus.mem_wdata[IE_BIT];
        SEL_DSR:  dsp_ie <= bus.mem_wdata[IE_BIT];
        SEL_MCR:  mcr    <= bus.mem_wdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_valid <= 1'b0;
      disp_data  <= '0;
    end else if (disp_hs) begin
      disp_valid <= 1'b0;
    end else if (ddr_load) begin
      disp_valid <= 1'b1;
      disp_data  <= bus.mem_wdata[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.mem_rdata <= '0;
      bus.mem_ready <= 1'b0;
      irq           <= 1'b0;
    end else begin
      bus.mem_rdata <= rdata_next;
      bus.mem_ready <= bus.io_hit;
      irq           <= irq_next;
    end
  end

endmodule
